// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending transaction controller and its core.
package vend_pkg;
  localparam int N_ITEMS    = 10;
  localparam int CREDIT_MAX = 99;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COLLECT   = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_REFUND    = 3'd4
  } ctrl_state_t;

  typedef enum logic [1:0] {
    VM_IDLE     = 2'd0,
    VM_CHECK    = 2'd1,
    VM_DISPENSE = 2'd2,
    VM_ERROR    = 2'd3
  } vm_state_t;

  // 8-bit sum so the credit-limit compare cannot wrap
  function automatic logic [7:0] credit_sum(input logic [6:0] a, input logic [6:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/vend_stock.sv
// Per-item 4-bit stock counters with restock, guarded decrement and an empty query.
module vend_stock #(
  parameter int N_ITEMS    = vend_pkg::N_ITEMS,
  parameter int STOCK_INIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restock,
  input  logic       dec_en,
  input  logic [3:0] dec_id,
  input  logic [3:0] query_id,
  output logic       empty
);
  logic [N_ITEMS:1][3:0] stock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stock <= {N_ITEMS{4'(STOCK_INIT)}};
    end else if (restock) begin
      stock <= {N_ITEMS{4'(STOCK_INIT)}};
    end else if (dec_en) begin
      for (int i = 1; i <= N_ITEMS; i++)
        if (dec_id == 4'(i) && stock[i] != 4'd0) stock[i] <= stock[i] - 4'd1;
    end
  end

  // Out-of-range IDs read as empty; the controller screens them before use.
  always_comb begin
    empty = 1'b1;
    for (int i = 1; i <= N_ITEMS; i++)
      if (query_id == 4'(i)) empty = (stock[i] == 4'd0);
  end
endmodule

// File: rtl/vend_txn_ctrl.sv
// Coin/selection sequencer in front of the vending core: credit, timeout, watchdog, refund.
module vend_txn_ctrl #(
  parameter int N_ITEMS     = vend_pkg::N_ITEMS,
  parameter int STOCK_INIT  = 3,
  parameter int CREDIT_MAX  = vend_pkg::CREDIT_MAX,
  parameter int TIMEOUT_CYC = 1000,
  parameter int WD_CYC      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [6:0] coin_amt,
  input  logic       sel_valid,
  input  logic [3:0] sel_id,
  input  logic       cancel,
  input  logic       restock,
  output logic       vm_coin,
  output logic [6:0] vm_value,
  output logic [3:0] vm_id,
  input  logic       vm_product,
  input  logic       vm_error,
  input  logic [6:0] vm_change,
  input  logic       vm_done,
  output logic [6:0] credit,
  output logic       coin_reject,
  output logic       sel_err,
  output logic       sold_out,
  output logic       refund_valid,
  output logic [6:0] refund_amt,
  output logic       vend_ok,
  output logic       fault,
  output logic       busy,
  output logic [2:0] state_o
);
  import vend_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int WW = $clog2(WD_CYC + 1);

  ctrl_state_t   state;
  logic [TW-1:0] tmo_cnt;
  logic [WW-1:0] wd_cnt;
  logic          cap_prod, cap_err;
  logic [6:0]    cap_chg;

  logic [7:0] sum;
  logic       coin_fits, sel_bad, item_empty, got_prod, got_err, vend_now;
  logic [6:0] chg_now;

  assign sum        = credit_sum(credit, coin_amt);
  assign coin_fits  = sum <= 8'(CREDIT_MAX);
  assign sel_bad    = (sel_id == 4'd0) || (sel_id > 4'(N_ITEMS));
  // A result and vm_done may land in the same cycle, so merge live and captured flags.
  assign got_prod   = vm_product | cap_prod;
  assign got_err    = vm_error | cap_err;
  assign chg_now    = vm_product ? vm_change : cap_chg;
  assign vend_now   = (state == S_WAIT_DONE) && vm_done && got_prod && !got_err;
  assign busy       = (state != S_IDLE);
  assign state_o    = state;

  vend_stock #(.N_ITEMS(N_ITEMS), .STOCK_INIT(STOCK_INIT)) u_stock (
    .clk      (clk),
    .rst_n    (rst_n),
    .restock  (restock && state == S_IDLE),
    .dec_en   (vend_now),
    .dec_id   (vm_id),
    .query_id (sel_id),
    .empty    (item_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      credit       <= '0;
      tmo_cnt      <= '0;
      wd_cnt       <= '0;
      cap_prod     <= 1'b0;
      cap_err      <= 1'b0;
      cap_chg      <= '0;
      vm_coin      <= 1'b0;
      vm_value     <= '0;
      vm_id        <= '0;
      coin_reject  <= 1'b0;
      sel_err      <= 1'b0;
      sold_out     <= 1'b0;
      refund_valid <= 1'b0;
      refund_amt   <= '0;
      vend_ok      <= 1'b0;
      fault        <= 1'b0;
    end else begin
      vm_coin      <= 1'b0;
      coin_reject  <= 1'b0;
      sel_err      <= 1'b0;
      sold_out     <= 1'b0;
      refund_valid <= 1'b0;
      refund_amt   <= '0;
      vend_ok      <= 1'b0;
      fault        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (coin_valid) begin
            if (coin_fits) begin
              credit  <= coin_amt;
              tmo_cnt <= TW'(1);
              state   <= S_COLLECT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (cancel) begin
            coin_reject  <= coin_valid;
            refund_valid <= 1'b1;
            refund_amt   <= credit;
            state        <= S_REFUND;
          end else if (sel_valid && !sel_bad && !item_empty) begin
            coin_reject <= coin_valid;
            vm_coin     <= 1'b1;
            vm_value    <= credit;
            vm_id       <= sel_id;
            state       <= S_ISSUE;
          end else begin
            sel_err  <= sel_valid && sel_bad;
            sold_out <= sel_valid && !sel_bad && item_empty;
            if (coin_valid && coin_fits) begin
              credit  <= sum[6:0];
              tmo_cnt <= TW'(1);
            end else begin
              // tmo_cnt counts cycles since the last accepted coin was sampled
              coin_reject <= coin_valid;
              if (tmo_cnt >= TW'(TIMEOUT_CYC - 1)) begin
                refund_valid <= 1'b1;
                refund_amt   <= credit;
                state        <= S_REFUND;
              end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
              end
            end
          end
        end
        S_ISSUE: begin
          coin_reject <= coin_valid;
          cap_prod    <= 1'b0;
          cap_err     <= 1'b0;
          cap_chg     <= '0;
          wd_cnt      <= '0;
          state       <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          coin_reject <= coin_valid;
          if (vm_product || vm_error) begin
            cap_prod <= vm_product;
            cap_err  <= vm_error;
            cap_chg  <= vm_change;
          end
          if (vm_done) begin
            refund_valid <= 1'b1;
            state        <= S_REFUND;
            if (got_prod && !got_err) begin
              refund_amt <= chg_now;
              vend_ok    <= 1'b1;
            end else begin
              refund_amt <= credit;
            end
          end else if (wd_cnt >= WW'(WD_CYC - 1)) begin
            fault        <= 1'b1;
            refund_valid <= 1'b1;
            refund_amt   <= credit;
            state        <= S_REFUND;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        S_REFUND: begin
          coin_reject <= coin_valid;
          credit      <= '0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed and randomized checks of vend_txn_ctrl against a behavioural core and purchase model.
module tb_vend_txn_ctrl;
  localparam int NI = 10;
  localparam int SI = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0, restock = 1'b0;
  logic [6:0] coin_amt = '0;
  logic [3:0] sel_id = '0;
  logic       vm_coin, vm_product, vm_error, vm_done;
  logic [6:0] vm_value, vm_change;
  logic [3:0] vm_id;
  logic [6:0] credit, refund_amt;
  logic       coin_reject, sel_err, sold_out, refund_valid, vend_ok, fault, busy;
  logic [2:0] state_o;

  int tests = 0;
  int fails = 0;
  bit core_hang = 1'b0;
  logic core_pend;
  int stk [1:NI];
  int amts [6] = '{1, 5, 10, 20, 25, 50};

  always #5 clk = ~clk;

  vend_txn_ctrl #(.N_ITEMS(NI), .STOCK_INIT(SI), .CREDIT_MAX(99), .TIMEOUT_CYC(16), .WD_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_amt(coin_amt),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .restock(restock),
    .vm_coin(vm_coin), .vm_value(vm_value), .vm_id(vm_id),
    .vm_product(vm_product), .vm_error(vm_error), .vm_change(vm_change), .vm_done(vm_done),
    .credit(credit), .coin_reject(coin_reject), .sel_err(sel_err), .sold_out(sold_out),
    .refund_valid(refund_valid), .refund_amt(refund_amt), .vend_ok(vend_ok),
    .fault(fault), .busy(busy), .state_o(state_o)
  );

  function automatic int price(input int id);
    return 5 * id;
  endfunction

  // Behavioural core: result one cycle after the request, done one cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vm_product <= 1'b0; vm_error <= 1'b0; vm_change <= '0; vm_done <= 1'b0; core_pend <= 1'b0;
    end else begin
      vm_product <= 1'b0; vm_error <= 1'b0; vm_done <= 1'b0; core_pend <= 1'b0;
      if (vm_coin) begin
        core_pend <= 1'b1;
        if (int'(vm_value) >= price(int'(vm_id))) begin
          vm_product <= 1'b1; vm_change <= 7'(int'(vm_value) - price(int'(vm_id)));
        end else begin
          vm_error <= 1'b1; vm_change <= vm_value;
        end
      end
      if (core_pend) vm_done <= !core_hang;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; restock = 1'b0;
  endtask

  task automatic coin(input int amt);
    coin_valid = 1'b1; coin_amt = 7'(amt); step();
  endtask

  task automatic sel(input int id);
    sel_valid = 1'b1; sel_id = 4'(id); step();
  endtask

  task automatic wait_refund(output int amt, output bit ok, output bit flt, output int n);
    bit seen = 1'b0;
    amt = -1; ok = 1'b0; flt = 1'b0; n = 0;
    while (!seen && n < 40) begin
      step(); n++;
      if (refund_valid) begin
        seen = 1'b1; amt = int'(refund_amt); ok = vend_ok; flt = fault;
      end
    end
    if (!seen) chk("refund_timeout", 32'd0, 1);
  endtask

  // Selection is accepted now; follow the core handshake through to IDLE.
  task automatic issue(input int id, input int cr, input int exp_ref, input bit exp_ok,
                       input int exp_lat, input bit exp_flt);
    int a, n; bit o, f;
    sel(id);
    chk("vm_coin", vm_coin, 1);
    chk("vm_value", vm_value, cr);
    chk("vm_id", vm_id, id);
    wait_refund(a, o, f, n);
    chk("refund_amt", a, exp_ref);
    chk("vend_ok", o, exp_ok);
    chk("fault", f, exp_flt);
    chk("refund_latency", n, exp_lat);
    step();
    chk("back_idle", state_o, 0);
  endtask

  task automatic cancel_chk(input int exp_ref);
    int a, n; bit o, f;
    cancel = 1'b1;
    wait_refund(a, o, f, n);
    chk("cancel_refund", a, exp_ref);
    chk("cancel_latency", n, 1);
    step();
    chk("cancel_idle", state_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed hang, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int a, n, cr, steps; bit o, f;

    // Reset state
    @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_credit", credit, 0);
    chk("rst_refund", {refund_valid, refund_amt}, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("idle_state", state_o, 0);

    // Normal vend: 10 + 10, item 3 at 15 -> change 5
    coin(10);
    chk("c1_credit", credit, 10);
    chk("c1_state", state_o, 1);
    chk("c1_busy", busy, 1);
    coin(10);
    chk("c2_credit", credit, 20);
    chk("c2_reject", coin_reject, 0);
    issue(3, 20, 5, 1'b1, 3, 1'b0);

    // Insufficient funds: item 5 at 25 with 10
    coin(10);
    issue(5, 10, 10, 1'b0, 3, 1'b0);

    // Drain item 3 (two left), then sold_out and cancel
    repeat (2) begin coin(15); issue(3, 15, 0, 1'b1, 3, 1'b0); end
    coin(5);
    sel(3);
    chk("sold_out", sold_out, 1);
    chk("sold_out_stay", state_o, 1);
    step();
    chk("sold_out_pulse", sold_out, 0);
    cancel_chk(5);

    // Invalid IDs
    coin(5);
    sel(12);
    chk("sel_err_12", sel_err, 1);
    chk("sel_err_stay", state_o, 1);
    sel(0);
    chk("sel_err_0", sel_err, 1);
    cancel_chk(5);

    // Restock in IDLE refills item 3
    restock = 1'b1; step();
    coin(15);
    issue(3, 15, 0, 1'b1, 3, 1'b0);

    // Timeout: refund of 20 sixteen cycles after the coin cycle
    coin(20);
    steps = 0;
    while (!refund_valid && steps < 40) begin step(); steps++; end
    chk("timeout_cycles", steps, 15);
    chk("timeout_amt", refund_amt, 20);
    step();
    chk("timeout_idle", state_o, 0);

    // Overflow and coin+cancel collision
    coin(50); coin(40);
    chk("ovf_pre", credit, 90);
    coin(10);
    chk("ovf_reject", coin_reject, 1);
    chk("ovf_credit", credit, 90);
    coin_valid = 1'b1; coin_amt = 7'd5; cancel = 1'b1;
    step();
    chk("cc_reject", coin_reject, 1);
    chk("cc_refund_valid", refund_valid, 1);
    chk("cc_refund_amt", refund_amt, 90);
    step();

    // Watchdog: no vm_done -> fault with full credit after 8 waiting cycles
    core_hang = 1'b1;
    coin(30);
    issue(2, 30, 30, 1'b0, 9, 1'b1);
    core_hang = 1'b0;

    // Drain item 1, then reset mid-transaction must reload stock
    repeat (3) begin coin(5); issue(1, 5, 0, 1'b1, 3, 1'b0); end
    coin(5);
    sel(1);
    chk("item1_empty", sold_out, 1);
    cancel_chk(5);
    coin(20);
    sel(4);
    step();
    chk("pre_rst_wait", state_o, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", state_o, 0);
    chk("mid_rst_credit", credit, 0);
    chk("mid_rst_vm", {vm_coin, vm_value, vm_id}, 0);
    chk("mid_rst_pulses", {coin_reject, sel_err, sold_out, refund_valid, vend_ok, fault, busy}, 0);
    chk("mid_rst_refund_amt", refund_amt, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    coin(5);
    issue(1, 5, 0, 1'b1, 3, 1'b0);

    // Randomized purchases against a credit/stock model
    restock = 1'b1; step();
    for (int i = 1; i <= NI; i++) stk[i] = SI;
    repeat (40) begin
      int nc, amt, r, id, er;
      cr = 0;
      nc = $urandom_range(1, 4);
      for (int k = 0; k < nc; k++) begin
        amt = amts[$urandom_range(0, 5)];
        coin(amt);
        if (cr + amt > 99) chk("r_reject", coin_reject, 1);
        else begin cr += amt; chk("r_reject", coin_reject, 0); end
        chk("r_credit", credit, cr);
      end
      r = $urandom_range(0, 7);
      if (r == 0) begin
        cancel_chk(cr);
      end else if (r == 1) begin
        id = $urandom_range(0, 1) ? 0 : $urandom_range(11, 15);
        sel(id);
        chk("r_sel_err", sel_err, 1);
        cancel_chk(cr);
      end else begin
        id = (r < 5) ? $urandom_range(1, 3) : $urandom_range(1, NI);
        if (stk[id] == 0) begin
          sel(id);
          chk("r_sold_out", sold_out, 1);
          cancel_chk(cr);
        end else if (cr >= price(id)) begin
          er = cr - price(id);
          stk[id]--;
          issue(id, cr, er, 1'b1, 3, 1'b0);
        end else begin
          issue(id, cr, cr, 1'b0, 3, 1'b0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vend_txn_ctrl.md
# vend_txn_ctrl

Transaction controller that sits in front of the `vending_machine` core and sequences it. It accumulates individual coins into a credit, accepts an item selection, and tracks per-item stock. It then issues one purchase request to the core and returns the core's change, or the full credit on failure, cancel or timeout, as a single refund pulse. The core itself is instantiated alongside this block by the parent; this block only drives and samples its ports.

## Interface
- `N_ITEMS`, 10: number of valid item IDs, 1..N_ITEMS.
- `STOCK_INIT`, 3: per-item stock loaded at reset and on restock; range 0..15.
- `CREDIT_MAX`, 99: maximum accumulated credit; must be ≤ 127.
- `TIMEOUT_CYC`, 1000: idle cycles allowed in COLLECT before an automatic refund.
- `WD_CYC`, 8: watchdog cycles allowed in WAIT_DONE.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `coin_valid` in 1: one coin inserted this cycle.
- `coin_amt` in 7: value of that coin.
- `sel_valid` in 1: item selection strobe.
- `sel_id` in 4: selected item.
- `cancel` in 1: buyer abort.
- `restock` in 1: reload every item's stock to STOCK_INIT.
- `vm_coin` out 1: one-cycle request pulse to the core.
- `vm_value` out 7: credit presented to the core.
- `vm_id` out 4: item presented to the core.
- `vm_product` in 1: core success flag.
- `vm_error` in 1: core insufficient-funds flag.
- `vm_change` in 7: core change amount.
- `vm_done` in 1: core completion flag.
- `credit` out 7: current accumulated credit.
- `coin_reject` out 1: pulse; the coin in this cycle was not accepted.
- `sel_err` out 1: pulse; invalid `sel_id`.
- `sold_out` out 1: pulse; the selected item has zero stock.
- `refund_valid` out 1: pulse; `refund_amt` is valid.
- `refund_amt` out 7: amount being returned.
- `vend_ok` out 1: pulse; an item was dispensed.
- `fault` out 1: pulse; watchdog expired.
- `busy` out 1: high in every state except IDLE.
- `state_o` out 3: current state encoding.

## Operation
- **States:** IDLE=0, COLLECT=1, ISSUE=2, WAIT_DONE=3, REFUND=4.
- **IDLE**
  - Credit is 0.
  - Accepted coin: credit ← coin_amt, go to COLLECT.
  - `restock` is honoured only in this state; it is ignored in all others.
- **COLLECT**, priority cancel > sel_valid > coin_valid > timeout:
  - **cancel:** go to REFUND with refund_amt = credit.
  - **sel_valid, `sel_id` 0 or > N_ITEMS:** pulse `sel_err`, stay.
  - **sel_valid, stock[sel_id] = 0:** pulse `sold_out`, stay.
  - **sel_valid, otherwise:** latch the ID, go to ISSUE.
  - **Coin that loses to cancel or an accepted selection:** pulse `coin_reject`.
  - **coin_valid:** if credit + coin_amt > CREDIT_MAX (8-bit compare), pulse `coin_reject` and leave credit unchanged; otherwise add the coin and reload the timeout counter.
  - **Timeout:** the counter reaches TIMEOUT_CYC−1 with no accepted coin → REFUND with refund_amt = credit.
- **ISSUE**
  - Lasts one cycle.
  - `vm_coin` = 1, `vm_value` = credit, `vm_id` = latched ID.
  - Next state is WAIT_DONE.
- **WAIT_DONE**
  - `vm_value` and `vm_id` are held stable.
  - On the cycle `vm_product` or `vm_error` is high, capture product, error and `vm_change`.
  - On `vm_done`, go to REFUND:
    - if product was captured: refund_amt = captured change, pulse `vend_ok`, decrement stock[ID];
    - otherwise: refund_amt = credit.
  - Watchdog: WD_CYC cycles without `vm_done` → pulse `fault`, refund_amt = credit, go to REFUND.
- **REFUND**
  - Lasts one cycle.
  - `refund_valid` = 1 even when refund_amt = 0.
  - Credit is cleared; next state is IDLE.
- **Coin rejection:** any `coin_valid` in ISSUE, WAIT_DONE or REFUND pulses `coin_reject`.
- **Stock:** 4-bit counters, never decremented below 0.

## Timing
- Reset values:
  - all pulse outputs are 0;
  - `credit`, `vm_value`, `vm_id`, `refund_amt` are 0;
  - `state_o` = 0 (IDLE), `busy` = 0;
  - stock = STOCK_INIT;
  - timers are cleared.
- Reset asserted mid-transaction aborts immediately. Credit is lost and no refund pulse is issued.
- A coin is visible on `credit` in the cycle after it is sampled.
- Core handshake, with ISSUE at cycle T:
  - core result visible at T+1;
  - `vm_done` at T+2;
  - REFUND (`refund_valid`, `vend_ok`) at T+3;
  - IDLE at T+4.
- Selection accepted at cycle S → `vm_coin` at S+1.
- Every pulse output is exactly one cycle wide and registered.
- `fault` and `refund_valid` assert in the same cycle when the watchdog fires.

## Structure
- Package `vend_pkg` holds:
  - `ctrl_state_t` (3-bit enum);
  - default constants `N_ITEMS`, `CREDIT_MAX`;
  - the `vm_state_t` encodings shared with the core.
- One sub-module, `vend_stock`: the stock counter array.
  - Inputs: `restock`, and a decrement enable plus index.
  - Outputs: an `empty` flag per queried ID.
- FSM, credit register, timers and the core interface live in `vend_txn_ctrl`.

## Test plan
- **Normal vend:** coins 10 + 10, then sel 3 (price 15) → `vm_value` = 20, `vm_id` = 3; then `refund_amt` = 5, `vend_ok` = 1, stock[3] 3→2.
- **Insufficient funds:** coin 10, sel 5 (price 25) → core error; `refund_amt` = 10, `vend_ok` = 0, stock[5] unchanged.
- **Selection rejects:** with STOCK_INIT = 1, coin 5 and sel 1 succeed. Then coin 5, sel 1 → `sold_out`, state stays COLLECT; cancel → `refund_amt` = 5. Sel 12 → `sel_err`.
- **Timeout:** TIMEOUT_CYC = 16, coin 20, then idle → `refund_valid` with 20 exactly 16 cycles after the coin.
- **Overflow and simultaneity:** credit 90 + coin 10 → `coin_reject`, credit stays 90. Coin + cancel in the same cycle → `coin_reject`, refund 90.
- **Watchdog and reset:** hold `vm_done` low → `fault` + refund of full credit after 8 cycles. Assert `rst_n` low during WAIT_DONE → all outputs 0 and stock reloaded.
